mpsoc_ahb3_ext_memory: RTL and testbench
========================================

// Module: mpsoc_ahb3_ext_memory
// PURPOSE
//  Parametrised AHB3-Lite slave memory for the MPSoC external bus port (ahb3_ext_*).
//  Replaces the 'x tie-off on the system's external port in 2D-mesh benches.
//  Adds configurable wait states, byte-lane writes and a two-cycle ERROR response.
//  Adds optional access statistics.
// PARAMETERS
//  HADDR_SIZE   32    address width
//  HDATA_SIZE   32    data width (32/64/128)
//  MEM_DEPTH    4096  words of HDATA_SIZE; word index = haddr[..] >> log2(HDATA_SIZE/8)
//  WAIT_STATES  0     hreadyout low cycles per OKAY data phase (0..15)
// PORTS
//  clk                input  1           clock
//  rst_n              input  1           asynchronous reset, active low
//  ahb3_hsel_i        input  1           slave select
//  ahb3_haddr_i       input  HADDR_SIZE  address
//  ahb3_hwdata_i      input  HDATA_SIZE  write data (data phase)
//  ahb3_hwrite_i      input  1           1=write
//  ahb3_hsize_i       input  3           transfer size
//  ahb3_hburst_i      input  3           burst type (ignored; each beat independent)
//  ahb3_hprot_i       input  4           protection (ignored)
//  ahb3_htrans_i      input  2           IDLE/BUSY/NONSEQ/SEQ
//  ahb3_hmastlock_i   input  1           lock (ignored)
//  ahb3_hready_i      input  1           bus HREADY
//  ahb3_hrdata_o      output HDATA_SIZE  read data
//  ahb3_hreadyout_o   output 1           slave ready
//  ahb3_hresp_o       output 1           0=OKAY 1=ERROR
// BEHAVIOUR
//  Reset: hreadyout_o=1, hresp_o=0, hrdata_o=0, state IDLE, wait counter 0.
//  Memory array not reset.
//  Accept: hsel_i & hready_i & htrans_i in {NONSEQ,SEQ}; register addr/write/size.
//  IDLE/BUSY or unselected: OKAY, zero wait, no access.
//  Illegal access, any of the following, goes to ERR1:
//  - word index >= MEM_DEPTH
//  - hsize > log2(HDATA_SIZE/8)
//  - address misaligned to hsize
//  FSM IDLE -> WAIT (WAIT_STATES>0) | DATA (WAIT_STATES=0) | ERR1 (illegal)
//  WAIT: hreadyout=0, counter loaded WAIT_STATES-1, decrements; DATA when 0.
//  DATA: hreadyout=1, hresp=0, one cycle.
//  - Read: hrdata = mem[idx]; unused lanes are 0.
//  - Write: hwdata lanes written on this edge using the byte mask.
//  - Byte mask = ((1<<(1<<hsize))-1) << haddr[log2(HDATA_SIZE/8)-1:0].
//  ERR1: hreadyout=0, hresp=1. ERR2: hreadyout=1, hresp=1. No memory access.
//  Pipelining: a new address phase is accepted in DATA or ERR2 (hreadyout=1).
//  - The next state follows that access; back-to-back beats run without bubbles.
//  Write then read of the same word: the write commits at the end of the write data phase.
//  - A read accepted in that cycle sees the new data; no forwarding path.
//  Master IDLE during ERR1: ERR2 still completes, then IDLE.
//  hrdata_o=0 outside read DATA cycles.
//  Reset mid-transfer: pending write dropped, outputs return to reset values.
// CONFIGURATION
//  MPSOC_AHB3_EXT_MEMORY_STATS_EN defined adds three outputs:
//  - rd_count_o, wr_count_o, err_count_o, 32 bits each, saturating.
//  - rd/wr_count_o increment on completed OKAY reads/writes (DATA cycle).
//  - err_count_o increments on entry to ERR1.
//  - All three reset to 0.
//  Macro undefined: these ports and counters are absent; bus behaviour is identical.
// STRUCTURE
//  Package mpsoc_ahb3_pkg:
//  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, HSIZE_* constants.
//  - State enum {IDLE,WAIT,DATA,ERR1,ERR2}.
//  Sub-module mpsoc_ahb3_ext_lane_decode: combinational size/offset to byte mask and alignment-error flag.
// TESTING
//  1 WAIT_STATES=0: NONSEQ write 0x10=0xDEADBEEF, then read 0x10.
//    -> hreadyout never low; read data 0xDEADBEEF one cycle after the read address phase.
//  2 WAIT_STATES=3: single read.
//    -> hreadyout low exactly 3 cycles, then high with OKAY.
//  3 Byte write hsize=0 to 0x13 data 0xAA000000 over 0x11223344, then read.
//    -> 0xAA223344.
//  4 Read addr MEM_DEPTH*4.
//    -> ERR1 (ready=0, resp=1), then ERR2 (ready=1, resp=1); memory unchanged.
//  5 hsize=2 at 0x02 (misaligned).
//    -> two-cycle ERROR; the following legal NONSEQ accepted in ERR2 completes OKAY.
//  6 Deassert rst_n during WAIT of a write to 0x20.
//    -> outputs at reset values; read of 0x20 returns the old contents.

Source files
------------

// File: rtl/mpsoc_ahb3_pkg.sv
// AHB3-Lite encodings and slave FSM states shared by the external memory block.
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE   = 3'd0;
  localparam logic [2:0] HSIZE_HWORD  = 3'd1;
  localparam logic [2:0] HSIZE_WORD   = 3'd2;
  localparam logic [2:0] HSIZE_DWORD  = 3'd3;
  localparam logic [2:0] HSIZE_128BIT = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DATA,
    ERR1,
    ERR2
  } ahb_state_t;

endpackage

// File: rtl/mpsoc_ahb3_ext_lane_decode.sv
// Combinational byte-lane decode: transfer size + low address bits to byte mask,
// plus size-too-wide and misalignment flags (zero latency, no flow control).
module mpsoc_ahb3_ext_lane_decode #(
  parameter int HDATA_SIZE = 32
) (
  input  logic [$clog2(HDATA_SIZE/8)-1:0] i_off,
  input  logic [2:0]                      i_hsize,
  output logic [HDATA_SIZE/8-1:0]         o_be,
  output logic                            o_size_err,
  output logic                            o_misaligned
);

  localparam int BE_W  = HDATA_SIZE / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic [7:0]       w_nbytes;
  logic [OFF_W-1:0] w_lo_mask;

  assign w_nbytes     = 8'd1 << i_hsize;
  // Truncation is harmless: oversized transfers are already flagged by o_size_err.
  assign w_lo_mask    = OFF_W'(w_nbytes - 8'd1);
  assign o_size_err   = (i_hsize > 3'(OFF_W));
  assign o_misaligned = |(i_off & w_lo_mask);

  always_comb begin
    o_be = '0;
    for (int b = 0; b < BE_W; b++) begin
      o_be[b] = (b >= int'(i_off)) && (b < int'(i_off) + int'(w_nbytes));
    end
  end

endmodule

// File: rtl/mpsoc_ahb3_ext_memory.sv
// AHB3-Lite slave memory: WAIT_STATES stall cycles per OKAY beat, two-cycle ERROR, pipelined accept.
// Optional saturating access counters when MPSOC_AHB3_EXT_MEMORY_STATS_EN is defined.
module mpsoc_ahb3_ext_memory
  import mpsoc_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ahb3_hsel_i,
  input  logic [HADDR_SIZE-1:0] ahb3_haddr_i,
  input  logic [HDATA_SIZE-1:0] ahb3_hwdata_i,
  input  logic                  ahb3_hwrite_i,
  input  logic [2:0]            ahb3_hsize_i,
  input  logic [2:0]            ahb3_hburst_i,
  input  logic [3:0]            ahb3_hprot_i,
  input  logic [1:0]            ahb3_htrans_i,
  input  logic                  ahb3_hmastlock_i,
  input  logic                  ahb3_hready_i,
  output logic [HDATA_SIZE-1:0] ahb3_hrdata_o,
  output logic                  ahb3_hreadyout_o,
  output logic                  ahb3_hresp_o
`ifdef MPSOC_AHB3_EXT_MEMORY_STATS_EN
  ,
  output logic [31:0]           rd_count_o,
  output logic [31:0]           wr_count_o,
  output logic [31:0]           err_count_o
`endif
);

  localparam int BE_W   = HDATA_SIZE / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WORD_W = HADDR_SIZE - OFF_W;
  localparam logic [WORD_W-1:0] DEPTH_W   = WORD_W'(MEM_DEPTH);
  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_STATES - 1);

  ahb_state_t       r_state, w_next_state;
  logic [3:0]       r_wait_cnt, w_wait_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_write;
  logic [BE_W-1:0]  r_be;

  logic [BE_W-1:0]   w_be;
  logic              w_size_err, w_misaligned, w_range_err, w_illegal;
  logic              w_addr_slot, w_accept;
  logic [WORD_W-1:0] w_word;
  logic              w_unused;

  logic [HDATA_SIZE-1:0] r_mem [MEM_DEPTH];

  // Burst type, protection and lock carry no meaning for a flat memory.
  assign w_unused = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i};

  mpsoc_ahb3_ext_lane_decode #(
    .HDATA_SIZE (HDATA_SIZE)
  ) u_lane_decode (
    .i_off        (ahb3_haddr_i[OFF_W-1:0]),
    .i_hsize      (ahb3_hsize_i),
    .o_be         (w_be),
    .o_size_err   (w_size_err),
    .o_misaligned (w_misaligned)
  );

  assign w_word      = ahb3_haddr_i[HADDR_SIZE-1:OFF_W];
  assign w_range_err = (w_word >= DEPTH_W);
  assign w_illegal   = w_range_err | w_size_err | w_misaligned;

  // Address phases are only taken while this slave is driving hreadyout high.
  assign w_addr_slot = (r_state == IDLE) || (r_state == DATA) || (r_state == ERR2);
  assign w_accept    = ahb3_hsel_i & ahb3_hready_i & w_addr_slot &
                       ((ahb3_htrans_i == HTRANS_NONSEQ) || (ahb3_htrans_i == HTRANS_SEQ));

  always_comb begin
    w_next_state     = r_state;
    w_wait_cnt_nxt   = r_wait_cnt;
    ahb3_hreadyout_o = 1'b1;
    ahb3_hresp_o     = HRESP_OKAY;
    unique case (r_state)
      IDLE, DATA, ERR2: begin
        if (r_state == ERR2) ahb3_hresp_o = HRESP_ERROR;
        if (w_accept) begin
          if (w_illegal) begin
            w_next_state = ERR1;
          end else if (WAIT_STATES > 0) begin
            w_next_state   = WAIT;
            w_wait_cnt_nxt = WAIT_LOAD;
          end else begin
            w_next_state = DATA;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        ahb3_hreadyout_o = 1'b0;
        if (r_wait_cnt == 4'd0) w_next_state = DATA;
        else                    w_wait_cnt_nxt = r_wait_cnt - 4'd1;
      end
      ERR1: begin
        ahb3_hreadyout_o = 1'b0;
        ahb3_hresp_o     = HRESP_ERROR;
        w_next_state     = ERR2;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_be       <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_idx   <= w_word[IDX_W-1:0];
        r_write <= ahb3_hwrite_i;
        r_be    <= w_be;
      end
    end
  end

  // Write commits at the edge closing the data phase, so a read accepted in
  // that same cycle reads the new word without any bypass.
  always_ff @(posedge clk) begin
    if (r_state == DATA && r_write) begin
      for (int b = 0; b < BE_W; b++) begin
        if (r_be[b]) r_mem[r_idx][b*8 +: 8] <= ahb3_hwdata_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    ahb3_hrdata_o = '0;
    if (r_state == DATA && !r_write) begin
      for (int b = 0; b < BE_W; b++) begin
        if (r_be[b]) ahb3_hrdata_o[b*8 +: 8] = r_mem[r_idx][b*8 +: 8];
      end
    end
  end

`ifdef MPSOC_AHB3_EXT_MEMORY_STATS_EN
  logic [31:0] r_rd_cnt, r_wr_cnt, r_err_cnt;
  logic        w_rd_done, w_wr_done, w_err_entry;

  assign w_rd_done   = (r_state == DATA) && !r_write;
  assign w_wr_done   = (r_state == DATA) &&  r_write;
  // ERR1 never repeats back to back, so every cycle heading into it is a fresh entry.
  assign w_err_entry = (w_next_state == ERR1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_rd_done   && (r_rd_cnt  != '1)) r_rd_cnt  <= r_rd_cnt  + 32'd1;
      if (w_wr_done   && (r_wr_cnt  != '1)) r_wr_cnt  <= r_wr_cnt  + 32'd1;
      if (w_err_entry && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign rd_count_o  = r_rd_cnt;
  assign wr_count_o  = r_wr_cnt;
  assign err_count_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_mpsoc_ahb3_ext_memory.sv
// Directed bench: one zero-wait and one three-wait instance share the bus signals, selected by hsel.
module tb_mpsoc_ahb3_ext_memory;
  import mpsoc_ahb3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel3;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hrdata0, hrdata3;
  logic        ready0, ready3, resp0, resp3;
`ifdef MPSOC_AHB3_EXT_MEMORY_STATS_EN
  logic [31:0] rd0, wr0, er0, rd3, wr3, er3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mpsoc_ahb3_ext_memory #(.WAIT_STATES(0)) dut0 (
    .clk (clk), .rst_n (rst_n),
    .ahb3_hsel_i (hsel0), .ahb3_haddr_i (haddr), .ahb3_hwdata_i (hwdata),
    .ahb3_hwrite_i (hwrite), .ahb3_hsize_i (hsize), .ahb3_hburst_i (3'b000),
    .ahb3_hprot_i (4'b0011), .ahb3_htrans_i (htrans), .ahb3_hmastlock_i (1'b0),
    .ahb3_hready_i (ready0), .ahb3_hrdata_o (hrdata0),
    .ahb3_hreadyout_o (ready0), .ahb3_hresp_o (resp0)
`ifdef MPSOC_AHB3_EXT_MEMORY_STATS_EN
    , .rd_count_o (rd0), .wr_count_o (wr0), .err_count_o (er0)
`endif
  );

  mpsoc_ahb3_ext_memory #(.WAIT_STATES(3)) dut3 (
    .clk (clk), .rst_n (rst_n),
    .ahb3_hsel_i (hsel3), .ahb3_haddr_i (haddr), .ahb3_hwdata_i (hwdata),
    .ahb3_hwrite_i (hwrite), .ahb3_hsize_i (hsize), .ahb3_hburst_i (3'b000),
    .ahb3_hprot_i (4'b0011), .ahb3_htrans_i (htrans), .ahb3_hmastlock_i (1'b0),
    .ahb3_hready_i (ready3), .ahb3_hrdata_o (hrdata3),
    .ahb3_hreadyout_o (ready3), .ahb3_hresp_o (resp3)
`ifdef MPSOC_AHB3_EXT_MEMORY_STATS_EN
    , .rd_count_o (rd3), .wr_count_o (wr3), .err_count_o (er3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aphase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    htrans = HTRANS_NONSEQ;
  endtask

  // Counts low-ready cycles on the three-wait instance, bounded at 20.
  task automatic wait_ready3(output int lows);
    lows = 0;
    @(negedge clk);
    while (!ready3 && lows < 20) begin
      lows++;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    rst_n = 1'b0; hsel0 = 1'b0; hsel3 = 1'b0;
    haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = HSIZE_WORD; htrans = HTRANS_IDLE;

    // Reset values
    @(negedge clk);
    check("rst_ready0", ready0, 1); check("rst_resp0", resp0, 0); check("rst_rdata0", hrdata0, 0);
    check("rst_ready3", ready3, 1); check("rst_resp3", resp3, 0); check("rst_rdata3", hrdata3, 0);
    @(negedge clk); rst_n = 1'b1;

    // Zero-wait write then pipelined read of the same word
    hsel0 = 1'b1;
    tick(); aphase(32'h10, 1'b1, HSIZE_WORD);
    @(negedge clk); check("t1_aphase_ready", ready0, 1);
    tick(); hwdata = 32'hDEADBEEF; aphase(32'h10, 1'b0, HSIZE_WORD);
    @(negedge clk); check("t1_wdata_ready", ready0, 1); check("t1_wdata_rdata", hrdata0, 0);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t1_rd_ready", ready0, 1); check("t1_rd_data", hrdata0, 32'hDEADBEEF);
    tick();
    @(negedge clk); check("t1_idle_rdata", hrdata0, 0);

    // Byte-lane write over a full word, then word and byte reads
    tick(); aphase(32'h10, 1'b1, HSIZE_WORD);
    tick(); hwdata = 32'h11223344; aphase(32'h13, 1'b1, HSIZE_BYTE);
    tick(); hwdata = 32'hAA000000; aphase(32'h10, 1'b0, HSIZE_WORD);
    tick(); aphase(32'h13, 1'b0, HSIZE_BYTE);
    @(negedge clk); check("t3_word", hrdata0, 32'hAA223344);
    tick(); aphase(32'h11, 1'b0, HSIZE_BYTE);
    @(negedge clk); check("t3_byte3", hrdata0, 32'hAA000000);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t3_byte1", hrdata0, 32'h00003300);

    // Out-of-range write must not alias word 0; out-of-range read errors too
    tick(); aphase(32'h0, 1'b1, HSIZE_WORD);
    tick(); hwdata = 32'hCAFEF00D; aphase(32'h4000, 1'b1, HSIZE_WORD);
    tick(); hwdata = 32'h12345678; htrans = HTRANS_IDLE;
    @(negedge clk); check("t4_err1_ready", ready0, 0); check("t4_err1_resp", resp0, 1);
    tick(); aphase(32'h4000, 1'b0, HSIZE_WORD);
    @(negedge clk); check("t4_err2_ready", ready0, 1); check("t4_err2_resp", resp0, 1);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t4_rd_err1_ready", ready0, 0); check("t4_rd_err1_rdata", hrdata0, 0);
    tick(); aphase(32'h0, 1'b0, HSIZE_WORD);
    @(negedge clk); check("t4_rd_err2_resp", resp0, 1);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t4_word0_resp", resp0, 0); check("t4_word0_data", hrdata0, 32'hCAFEF00D);

    // Misaligned word, legal read accepted during ERR2
    tick(); aphase(32'h2, 1'b0, HSIZE_WORD);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t5_err1_ready", ready0, 0); check("t5_err1_resp", resp0, 1);
    tick(); aphase(32'h10, 1'b0, HSIZE_WORD);
    @(negedge clk); check("t5_err2_ready", ready0, 1); check("t5_err2_resp", resp0, 1);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t5_ok_resp", resp0, 0); check("t5_ok_data", hrdata0, 32'hAA223344);

    // Transfer wider than the bus
    tick(); aphase(32'h0, 1'b0, HSIZE_DWORD);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t5_size_resp", resp0, 1);
    tick(); tick();
    hsel0 = 1'b0;

    // Three wait states on write and read
    hsel3 = 1'b1;
    tick(); aphase(32'h20, 1'b1, HSIZE_WORD);
    tick(); hwdata = 32'h0BADC0DE; htrans = HTRANS_IDLE;
    wait_ready3(lows); check("t2_wr_waits", lows, 3);
    tick(); aphase(32'h20, 1'b0, HSIZE_WORD);
    tick(); htrans = HTRANS_IDLE;
    @(negedge clk); check("t2_wait_rdata", hrdata3, 0);
    wait_ready3(lows);
    check("t2_rd_waits", lows, 2);
    check("t2_rd_resp", resp3, 0); check("t2_rd_data", hrdata3, 32'h0BADC0DE);

    // Reset during the wait of a write drops it
    tick(); aphase(32'h20, 1'b1, HSIZE_WORD);
    tick(); hwdata = 32'hFFFFFFFF; htrans = HTRANS_IDLE;
    @(negedge clk); check("t6_wait_ready", ready3, 0);
    rst_n = 1'b0; #1;
    check("t6_rst_ready", ready3, 1); check("t6_rst_resp", resp3, 0); check("t6_rst_rdata", hrdata3, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    tick(); aphase(32'h20, 1'b0, HSIZE_WORD);
    tick(); htrans = HTRANS_IDLE;
    wait_ready3(lows); check("t6_rd_waits", lows, 3);
    check("t6_old_data", hrdata3, 32'h0BADC0DE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
